// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: small byte FIFO feeding an 8N1 serializer (LSB first, idle-high)
// with its own baud-tick generator; tx_done marks the final cycle of each stop bit.
//
//   state   | meaning
//   S_IDLE  | line high; pops the FIFO head whenever a byte is waiting
//   S_START | start bit, line low for 16 baud ticks
//   S_DATA  | DBIT data bits, LSB first, 16 baud ticks each
//   S_STOP  | stop bit, line high for SB_TICK baud ticks
module uart_tx_fifo #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 326,
    parameter int FIFO_W  = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_uart,
    input  logic [7:0] w_data,
    output logic       tx_full,
    output logic       tx_empty,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx
);

    localparam int CW      = $clog2(DVSR);
    localparam int SW      = $clog2((SB_TICK > 16) ? SB_TICK : 16);
    localparam int NW      = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int DEPTH_N = 1 << FIFO_W;

    localparam logic [CW-1:0]   BAUD_LAST   = CW'(DVSR - 1);
    localparam logic [SW-1:0]   S_BIT_LAST  = SW'(15);
    localparam logic [SW-1:0]   S_STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [NW-1:0]   N_LAST      = NW'(DBIT - 1);
    localparam logic [FIFO_W:0] DEPTH       = {1'b1, {FIFO_W{1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [7:0]        r_mem [0:DEPTH_N-1];
    logic [FIFO_W-1:0] r_wr_ptr;
    logic [FIFO_W-1:0] r_rd_ptr;
    logic [FIFO_W:0]   r_count;

    logic [CW-1:0]     r_baud;
    state_t            r_state;
    logic [SW-1:0]     r_s;
    logic [NW-1:0]     r_n;
    logic [7:0]        r_b;
    logic              r_tx;

    logic              w_full;
    logic              w_empty;
    logic              w_push;
    logic              w_pop;
    logic              w_tick;
    state_t            w_state_next;
    logic [SW-1:0]     w_s_next;
    logic [NW-1:0]     w_n_next;
    logic [7:0]        w_b_next;
    logic              w_tx_next;
    logic              w_done;

    assign w_full  = (r_count == DEPTH);
    assign w_empty = (r_count == '0);
    assign w_push  = wr_uart && !w_full;
    assign w_pop   = (r_state == S_IDLE) && !w_empty;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Held at zero while idle so every frame starts on a full-length tick period.
    assign w_tick = (r_state != S_IDLE) && (r_baud == BAUD_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_baud <= '0;
        end else if (r_state == S_IDLE || w_tick) begin
            r_baud <= '0;
        end else begin
            r_baud <= r_baud + 1'b1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_s_next     = r_s;
        w_n_next     = r_n;
        w_b_next     = r_b;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_b_next     = r_mem[r_rd_ptr];
                    w_s_next     = '0;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_tick) begin
                    if (r_s == S_BIT_LAST) begin
                        w_s_next     = '0;
                        w_n_next     = '0;
                        w_state_next = S_DATA;
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (w_tick) begin
                    if (r_s == S_BIT_LAST) begin
                        w_s_next = '0;
                        w_b_next = {1'b0, r_b[7:1]};
                        if (r_n == N_LAST) begin
                            w_state_next = S_STOP;
                        end else begin
                            w_n_next = r_n + 1'b1;
                        end
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (w_tick) begin
                    if (r_s == S_STOP_LAST) begin
                        w_done       = 1'b1;
                        w_state_next = S_IDLE;
                    end else begin
                        w_s_next = r_s + 1'b1;
                    end
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase

        // Line level follows the state being entered so tx changes exactly on bit boundaries.
        case (w_state_next)
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = w_b_next[0];
            default: w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_s     <= '0;
            r_n     <= '0;
            r_b     <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_s     <= w_s_next;
            r_n     <= w_n_next;
            r_b     <= w_b_next;
            r_tx    <= w_tx_next;
        end
    end

    assign tx_full  = w_full;
    assign tx_empty = w_empty;
    assign tx_busy  = (r_state != S_IDLE);
    assign tx_done  = w_done;
    assign tx       = r_tx;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo at DVSR=4 (64 clk per bit): a line monitor decodes every frame
// and compares it with bytes queued at write time; a second SB_TICK=32 instance checks stop length.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_uart;
    logic [7:0] w_data;
    logic       tx_full, tx_empty, tx_busy, tx_done, tx;
    logic       wr2;
    logic [7:0] wdata2;
    logic       full2, empty2, busy2, done2, tx2;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;

    logic [7:0] exp_q[$];
    int         gap_q[$];

    logic       mon_busy = 1'b0;
    int         mon_off = 0;
    int         mon_bad = 0;
    logic [7:0] mon_exp = 8'h00;
    logic [7:0] mon_rx = 8'h00;
    int         last_end = 0;
    int         frames = 0;
    int         idle_done = 0;

    uart_tx_fifo #(.DVSR(4)) u_dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_uart  (wr_uart),
        .w_data   (w_data),
        .tx_full  (tx_full),
        .tx_empty (tx_empty),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .tx       (tx)
    );

    uart_tx_fifo #(.DVSR(4), .SB_TICK(32)) u_dut_sb32 (
        .clk      (clk),
        .reset_n  (reset_n),
        .wr_uart  (wr2),
        .w_data   (wdata2),
        .tx_full  (full2),
        .tx_empty (empty2),
        .tx_busy  (busy2),
        .tx_done  (done2),
        .tx       (tx2)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Expected line level at a given clk offset into a 16*DVSR=64-clk-per-bit frame.
    function automatic logic exp_level(input int o, input logic [7:0] b);
        logic [2:0] idx;
        if (o < 64) return 1'b0;
        if (o < 576) begin
            idx = 3'((o - 64) / 64);
            return b[idx];
        end
        return 1'b1;
    endfunction

    // Line monitor for the default instance: offset 0 is the first START cycle.
    initial begin
        logic [2:0] bi;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                mon_busy = 1'b0;
            end else if (!mon_busy) begin
                if (tx_done) idle_done++;
                if (tx === 1'b0) begin
                    mon_busy = 1'b1;
                    mon_off  = 0;
                    mon_bad  = 0;
                    mon_rx   = 8'h00;
                    gap_q.push_back(cyc - last_end);
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_frame", 1, 0);
                        mon_exp = 8'h00;
                    end else begin
                        mon_exp = exp_q.pop_front();
                    end
                end
            end else begin
                mon_off++;
            end
            if (mon_busy && reset_n) begin
                if (tx !== exp_level(mon_off, mon_exp) || tx_busy !== 1'b1) mon_bad++;
                if (mon_off != 639 && tx_done) mon_bad++;
                if (mon_off >= 64 && mon_off < 576 && (mon_off % 64) == 32) begin
                    bi = 3'((mon_off - 64) / 64);
                    mon_rx[bi] = tx;
                end
                if (mon_off == 639) begin
                    check_eq("done_at_stop_end", tx_done, 1);
                    check_eq("frame_byte", mon_rx, mon_exp);
                    check_eq("frame_shape", mon_bad, 0);
                    last_end = cyc;
                    frames++;
                    mon_busy = 1'b0;
                end
            end
        end
    end

    task automatic wait_drain(input int budget);
        int t;
        t = 0;
        while ((exp_q.size() != 0 || mon_busy || tx_busy) && t < budget) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_eq("drain_timeout", (t >= budget), 0);
    endtask

    initial begin
        int t;
        int lows;
        int frames_before;
        int done_off;
        int shape_bad;
        int stop_bad;
        int post_bad;
        logic [7:0] rx;
        logic [2:0] bi;

        wr_uart = 1'b0;
        w_data  = 8'h00;
        wr2     = 1'b0;
        wdata2  = 8'h00;
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        check_eq("rst_tx", tx, 1);
        check_eq("rst_empty", tx_empty, 1);
        check_eq("rst_full", tx_full, 0);
        check_eq("rst_busy", tx_busy, 0);
        check_eq("rst_done", tx_done, 0);

        // Idle line
        lows = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        @(posedge clk);
        #1;
        check_eq("idle_tx_high", lows, 0);
        check_eq("idle_no_done", idle_done, 0);
        check_eq("idle_empty", tx_empty, 1);
        check_eq("idle_busy", tx_busy, 0);

        // Single frame 0xCD
        w_data  = 8'hCD;
        wr_uart = 1'b1;
        exp_q.push_back(8'hCD);
        @(posedge clk);
        #1 wr_uart = 1'b0;
        wait_drain(2000);
        check_eq("single_frames", frames, 1);
        check_eq("single_busy_after", tx_busy, 0);
        check_eq("single_empty_after", tx_empty, 1);

        // Burst of six writes into a depth-4 FIFO; first byte drains immediately
        gap_q.delete();
        for (int k = 0; k < 6; k++) begin
            w_data  = 8'(k + 1);
            wr_uart = 1'b1;
            if (k < 5) exp_q.push_back(8'(k + 1));
            @(posedge clk);
            #1;
            check_eq("burst_full", tx_full, (k >= 4));
        end
        wr_uart = 1'b0;
        wait_drain(5000);
        check_eq("burst_frames", gap_q.size(), 5);
        for (int k = 1; k < 5; k++) begin
            if (k < gap_q.size()) check_eq("burst_gap", gap_q[k], 2);
        end

        // Write on the pop cycle while full is dropped
        for (int k = 0; k < 5; k++) begin
            w_data  = 8'(8'h10 + k);
            wr_uart = 1'b1;
            exp_q.push_back(8'(8'h10 + k));
            @(posedge clk);
            #1;
        end
        wr_uart = 1'b0;
        check_eq("pop_full_set", tx_full, 1);
        t = 0;
        while (tx_busy && t < 1000) begin
            @(posedge clk);
            #1;
            t++;
        end
        check_eq("pop_idle_timeout", (t >= 1000), 0);
        check_eq("pop_full_at_pop", tx_full, 1);
        w_data  = 8'hEE;
        wr_uart = 1'b1;
        @(posedge clk);
        #1 wr_uart = 1'b0;
        check_eq("pop_full_cleared", tx_full, 0);
        check_eq("pop_busy_again", tx_busy, 1);
        repeat (20) @(posedge clk);
        #1;
        w_data  = 8'h77;
        wr_uart = 1'b1;
        exp_q.push_back(8'h77);
        @(posedge clk);
        #1 wr_uart = 1'b0;
        check_eq("pop_refill_full", tx_full, 1);
        wait_drain(6000);

        // Reset in the middle of a frame with bytes queued
        for (int k = 0; k < 3; k++) begin
            w_data  = (k == 0) ? 8'hA5 : 8'(8'h11 * k);
            wr_uart = 1'b1;
            exp_q.push_back(w_data);
            @(posedge clk);
            #1;
        end
        wr_uart = 1'b0;
        repeat (276) @(posedge clk);
        #1;
        check_eq("abort_busy_before", tx_busy, 1);
        check_eq("abort_tx_low_before", tx, 0);
        check_eq("abort_queued", tx_empty, 0);
        #2 reset_n = 1'b0;
        #1;
        check_eq("abort_tx_async", tx, 1);
        check_eq("abort_empty_async", tx_empty, 1);
        check_eq("abort_busy_async", tx_busy, 0);
        exp_q.delete();
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        check_eq("abort_full_after", tx_full, 0);
        frames_before = frames;
        lows = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || tx_busy !== 1'b0) lows++;
        end
        check_eq("abort_no_frame", lows, 0);
        check_eq("abort_frame_count", frames, frames_before);
        check_eq("abort_empty_after", tx_empty, 1);

        // SB_TICK=32 instance: stop bit 128 clk, frame 704 clk
        @(posedge clk);
        #1;
        wdata2 = 8'h55;
        wr2    = 1'b1;
        @(posedge clk);
        #1 wr2 = 1'b0;
        t = 0;
        while (tx2 !== 1'b0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check_eq("sb32_start_timeout", (t >= 100), 0);
        done_off  = -1;
        shape_bad = 0;
        stop_bad  = 0;
        post_bad  = 0;
        rx        = 8'h00;
        for (int o = 0; o < 720; o++) begin
            if (o > 0) @(negedge clk);
            if (done2 === 1'b1 && done_off < 0) done_off = o;
            if (o < 576 && tx2 !== exp_level(o, 8'h55)) shape_bad++;
            if (o >= 64 && o < 576 && (o % 64) == 32) begin
                bi = 3'((o - 64) / 64);
                rx[bi] = tx2;
            end
            if (o >= 576 && o <= 703 && (tx2 !== 1'b1 || busy2 !== 1'b1)) stop_bad++;
            if (o >= 704 && (tx2 !== 1'b1 || busy2 !== 1'b0)) post_bad++;
        end
        check_eq("sb32_byte", rx, 8'h55);
        check_eq("sb32_shape", shape_bad, 0);
        check_eq("sb32_stop_high", stop_bad, 0);
        check_eq("sb32_done_offset", done_off, 703);
        check_eq("sb32_idle_after", post_bad, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
